vga_tile_arbiter: RTL and testbench
===================================

# vga_tile_arbiter

Shares one single-port, synchronous-read tile memory (40x30 grid of 16x16-pixel tiles) between the VGA pixel pipeline and the snake game logic. Sits between the VGA timing controller (coordinates, sync) and the renderer. Pixel fetches are scheduled in fixed slots with strict priority; game read and write requests fill the remaining cycles. The block also emits a once-per-frame tick for pacing game updates.

## Interface
- TILE_W, 4, tile code width (bits)
- iCLK  in  1  pixel clock
- iRST_N  in  1  reset, asynchronous, active-low
- iCoord_X, iCoord_Y  in  10 each  current pixel coordinate from VGA timing
- iPix_Valid  in  1  active-video flag aligned with iCoord_X/Y
- iVGA_V_SYNC  in  1  vertical sync, active-low
- oMem_Addr  out  11  tile memory address
- oMem_WE  out  1  tile memory write enable
- oMem_WData  out  TILE_W  tile memory write data
- iMem_RData  in  TILE_W  read data, valid the cycle after the address
- iG_Req  in  1  game request; held with fields stable until oG_Ack
- iG_We  in  1  1 = write, 0 = read
- iG_Addr  in  11  linear tile index
- iG_WData  in  TILE_W  game write data
- oG_Ack  out  1  one-cycle grant pulse
- oG_RData  out  TILE_W  game read data
- oG_RValid  out  1  one-cycle read-data strobe
- oTile  out  TILE_W  tile code under the delayed pixel
- oCoord_X_d, oCoord_Y_d  out  10 each  coordinates delayed by 3 cycles
- oPix_Valid_d  out  1  iPix_Valid delayed by 3 cycles
- oFrame_Tick  out  1  one-cycle pulse per frame

## Operation
- Pixel slot: iPix_Valid=1 and iCoord_X[3:0]==0. Address = (Y>>4)*40 + (X>>4), computed as (Y>>4)<<5 + (Y>>4)<<3 + (X>>4), 11-bit.
- Arbiter FSM, one memory command per cycle, states: S_IDLE, S_PIX, S_GRD, S_GWR. Each cycle the next state is chosen from the current inputs:
  - pixel slot → S_PIX
  - else iG_Req with grant allowed → S_GRD or S_GWR per iG_We
  - else S_IDLE
- Pixel always beats game. A game request colliding with a pixel slot is granted on the next free cycle.
- The game port sees at most one lost cycle per 16 during active video.
- Game address ≥1200:
  - writes: acked, oMem_WE held 0
  - reads: acked, oG_RData=0
- oTile is loaded from iMem_RData two cycles after an S_PIX command and held until the next load.
- Frame tick: iVGA_V_SYNC is registered and its falling edge detected. oFrame_Tick pulses the cycle after the edge.
- Vblank flag: set on the V_SYNC falling edge, cleared on the first rising edge of iPix_Valid.
- Reset values:
  - all outputs 0
  - FSM = S_IDLE
  - vblank flag = 1
  - V_SYNC register = 1
- Reset mid-transaction drops the request without ack. The game must re-request.

## Timing
- Decision in cycle n. oMem_Addr, oMem_WE, oMem_WData and oG_Ack are registered and valid in cycle n+1.
- The memory returns iMem_RData in n+2.
- oTile and oG_RData/oG_RValid are registered in n+3.
- Pixel pipeline latency is exactly 3 cycles. oTile is aligned with oCoord_X_d/oCoord_Y_d/oPix_Valid_d.
- oMem_WE is high only in the S_GWR command cycle, for one cycle.
- Back-to-back game requests: a new request may be granted the cycle after oG_Ack, provided the requester updates its fields.

## Configuration
- VGA_TILE_FRAME_LOCK_EN defined: game writes are granted only while the vblank flag is 1. Reads are granted in any free cycle. A blocked write waits without ack.
- VGA_TILE_FRAME_LOCK_EN undefined: writes are granted in any free cycle, the same as reads.

## Structure
- Package vga_tile_pkg holds:
  - constants TILE_COLS=40, TILE_ROWS=30, TILE_COUNT=1200, TILE_SHIFT=4, PIPE_LAT=3
  - arbiter state enum
- Sub-module vga_tile_addr: combinational (X,Y)→linear-index calculator, shared logic for the range check.

## Test plan
- Pixel slot: X=32, Y=16, iPix_Valid=1 → oMem_Addr=42 in n+1. With iMem_RData=5 in n+2, oTile=5 in n+3 and stays 5 through the delayed coordinate X=47.
- Collision: game read request issued in the same cycle as a pixel slot at X=0, Y=0 → first command is the pixel address 0. oG_Ack follows one cycle later, and oG_RValid two cycles after the ack.
- Out-of-range: game write to address 1200 → oG_Ack=1 with oMem_WE=0. Game read of 1500 → oG_RData=0 with oG_RValid=1.
- Frame tick: iVGA_V_SYNC 1→0 → exactly one oFrame_Tick pulse one cycle later. No further pulse while V_SYNC stays low.
- VGA_TILE_FRAME_LOCK_EN: write request during active video → no ack until the V_SYNC falling edge, then ack within 2 cycles. A read issued at the same time is acked immediately.
- Reset: assert iRST_N=0 with iG_Req held high mid-line → all outputs 0 immediately. After release, the first pixel slot or the held request is served normally.

Source files
------------

// File: rtl/vga_tile_pkg.sv
// rtl/vga_tile_pkg.sv - shared constants and arbiter state type for the VGA tile arbiter
package vga_tile_pkg;
    localparam int TILE_COLS  = 40;
    localparam int TILE_ROWS  = 30;
    localparam int TILE_COUNT = 1200;
    localparam int TILE_SHIFT = 4;
    localparam int PIPE_LAT   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PIX  = 2'd1,
        S_GRD  = 2'd2,
        S_GWR  = 2'd3
    } arb_state_t;
endpackage

// File: rtl/vga_tile_addr.sv
// rtl/vga_tile_addr.sv - pixel coordinate to linear tile index, plus game address range check
module vga_tile_addr
    import vga_tile_pkg::*;
(
    input  logic [9:0]  coord_x,
    input  logic [9:0]  coord_y,
    input  logic [10:0] g_addr,
    output logic [10:0] pix_addr,
    output logic        g_in_range
);
    logic [10:0] row;
    logic [10:0] col;

    assign row = 11'(coord_y >> TILE_SHIFT);
    assign col = 11'(coord_x >> TILE_SHIFT);

    // row * 40 as row*32 + row*8 keeps the index path adder-only
    assign pix_addr   = (row << 5) + (row << 3) + col;
    assign g_in_range = (g_addr < 11'(TILE_COUNT));
endmodule

// File: rtl/vga_tile_arbiter.sv
// rtl/vga_tile_arbiter.sv - tile memory arbiter between pixel fetch and game port, with frame tick
// Optional write gating to vblank: VGA_TILE_FRAME_LOCK_EN
module vga_tile_arbiter
    import vga_tile_pkg::*;
#(
    parameter int TILE_W = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [9:0]        iCoord_X,
    input  logic [9:0]        iCoord_Y,
    input  logic              iPix_Valid,
    input  logic              iVGA_V_SYNC,
    output logic [10:0]       oMem_Addr,
    output logic              oMem_WE,
    output logic [TILE_W-1:0] oMem_WData,
    input  logic [TILE_W-1:0] iMem_RData,
    input  logic              iG_Req,
    input  logic              iG_We,
    input  logic [10:0]       iG_Addr,
    input  logic [TILE_W-1:0] iG_WData,
    output logic              oG_Ack,
    output logic [TILE_W-1:0] oG_RData,
    output logic              oG_RValid,
    output logic [TILE_W-1:0] oTile,
    output logic [9:0]        oCoord_X_d,
    output logic [9:0]        oCoord_Y_d,
    output logic              oPix_Valid_d,
    output logic              oFrame_Tick
);
    arb_state_t        state_q, state_d;
    logic [10:0]       pix_addr;
    logic              g_in_range;
    logic              pix_slot;
    logic              wr_allowed;

    logic [10:0]       cmd_addr_q, cmd_addr_d;
    logic [TILE_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              cmd_oor_q, cmd_oor_d;
    logic              cmd_pix, cmd_grd, mem_we, g_ack;

    logic              rd_pix_q, rd_pix_d;
    logic              rd_g_q, rd_g_d;
    logic              rd_oor_q, rd_oor_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] g_rdata_q, g_rdata_d;
    logic              g_rvalid_q, g_rvalid_d;

    logic              vs_q, vs_d, vs_fall;
    logic              pv_q, pv_d;
    logic              vblank_q, vblank_d;
    logic              tick_q, tick_d;

    logic [9:0]          x_dly_q [PIPE_LAT];
    logic [9:0]          x_dly_d [PIPE_LAT];
    logic [9:0]          y_dly_q [PIPE_LAT];
    logic [9:0]          y_dly_d [PIPE_LAT];
    logic [PIPE_LAT-1:0] v_dly_q, v_dly_d;

    vga_tile_addr u_addr (
        .coord_x    (iCoord_X),
        .coord_y    (iCoord_Y),
        .g_addr     (iG_Addr),
        .pix_addr   (pix_addr),
        .g_in_range (g_in_range)
    );

    assign pix_slot = iPix_Valid && (iCoord_X[TILE_SHIFT-1:0] == '0);

`ifdef VGA_TILE_FRAME_LOCK_EN
    assign wr_allowed = vblank_q;
`else
    assign wr_allowed = 1'b1;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_oor_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_oor_q   <= cmd_oor_d;
        end
    end

    // Pixel slots win unconditionally; a deferred game request simply stays asserted
    always_comb begin
        state_d     = S_IDLE;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_oor_d   = 1'b0;
        if (pix_slot) begin
            state_d    = S_PIX;
            cmd_addr_d = pix_addr;
        end else if (iG_Req && (!iG_We || wr_allowed)) begin
            state_d    = iG_We ? S_GWR : S_GRD;
            cmd_addr_d = iG_Addr;
            cmd_oor_d  = !g_in_range;
            if (iG_We) begin
                cmd_wdata_d = iG_WData;
            end
        end
    end

    always_comb begin
        mem_we  = (state_q == S_GWR) && !cmd_oor_q;
        g_ack   = (state_q == S_GRD) || (state_q == S_GWR);
        cmd_pix = (state_q == S_PIX);
        cmd_grd = (state_q == S_GRD);
    end

    always_comb begin
        rd_pix_d   = cmd_pix;
        rd_g_d     = cmd_grd;
        rd_oor_d   = cmd_oor_q;
        tile_d     = rd_pix_q ? iMem_RData : tile_q;
        g_rdata_d  = g_rdata_q;
        g_rvalid_d = rd_g_q;
        if (rd_g_q) begin
            g_rdata_d = rd_oor_q ? '0 : iMem_RData;
        end

        vs_d     = iVGA_V_SYNC;
        vs_fall  = vs_q && !iVGA_V_SYNC;
        pv_d     = iPix_Valid;
        tick_d   = vs_fall;
        vblank_d = vblank_q;
        if (vs_fall) begin
            vblank_d = 1'b1;
        end else if (iPix_Valid && !pv_q) begin
            vblank_d = 1'b0;
        end

        x_dly_d[0] = iCoord_X;
        y_dly_d[0] = iCoord_Y;
        v_dly_d    = {v_dly_q[PIPE_LAT-2:0], iPix_Valid};
        for (int i = 1; i < PIPE_LAT; i++) begin
            x_dly_d[i] = x_dly_q[i-1];
            y_dly_d[i] = y_dly_q[i-1];
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_pix_q   <= 1'b0;
            rd_g_q     <= 1'b0;
            rd_oor_q   <= 1'b0;
            tile_q     <= '0;
            g_rdata_q  <= '0;
            g_rvalid_q <= 1'b0;
            vs_q       <= 1'b1;
            pv_q       <= 1'b0;
            vblank_q   <= 1'b1;
            tick_q     <= 1'b0;
            v_dly_q    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                x_dly_q[i] <= '0;
                y_dly_q[i] <= '0;
            end
        end else begin
            rd_pix_q   <= rd_pix_d;
            rd_g_q     <= rd_g_d;
            rd_oor_q   <= rd_oor_d;
            tile_q     <= tile_d;
            g_rdata_q  <= g_rdata_d;
            g_rvalid_q <= g_rvalid_d;
            vs_q       <= vs_d;
            pv_q       <= pv_d;
            vblank_q   <= vblank_d;
            tick_q     <= tick_d;
            v_dly_q    <= v_dly_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                x_dly_q[i] <= x_dly_d[i];
                y_dly_q[i] <= y_dly_d[i];
            end
        end
    end

    assign oMem_Addr    = cmd_addr_q;
    assign oMem_WE      = mem_we;
    assign oMem_WData   = cmd_wdata_q;
    assign oG_Ack       = g_ack;
    assign oG_RData     = g_rdata_q;
    assign oG_RValid    = g_rvalid_q;
    assign oTile        = tile_q;
    assign oCoord_X_d   = x_dly_q[PIPE_LAT-1];
    assign oCoord_Y_d   = y_dly_q[PIPE_LAT-1];
    assign oPix_Valid_d = v_dly_q[PIPE_LAT-1];
    assign oFrame_Tick  = tick_q;
endmodule

// File: tb/tb_vga_tile_arbiter.sv
// tb/tb_vga_tile_arbiter.sv - randomized game traffic over a compressed raster against a reference model
module tb_vga_tile_arbiter;
    localparam int TW   = 4;
    localparam int NCYC = 3200;

    logic          iCLK, iRST_N;
    logic [9:0]    iCoord_X, iCoord_Y;
    logic          iPix_Valid, iVGA_V_SYNC;
    logic [10:0]   oMem_Addr;
    logic          oMem_WE;
    logic [TW-1:0] oMem_WData, iMem_RData;
    logic          iG_Req, iG_We;
    logic [10:0]   iG_Addr;
    logic [TW-1:0] iG_WData;
    logic          oG_Ack, oG_RValid;
    logic [TW-1:0] oG_RData, oTile;
    logic [9:0]    oCoord_X_d, oCoord_Y_d;
    logic          oPix_Valid_d, oFrame_Tick;

    vga_tile_arbiter #(.TILE_W(TW)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
        .iPix_Valid(iPix_Valid), .iVGA_V_SYNC(iVGA_V_SYNC),
        .oMem_Addr(oMem_Addr), .oMem_WE(oMem_WE), .oMem_WData(oMem_WData),
        .iMem_RData(iMem_RData),
        .iG_Req(iG_Req), .iG_We(iG_We), .iG_Addr(iG_Addr), .iG_WData(iG_WData),
        .oG_Ack(oG_Ack), .oG_RData(oG_RData), .oG_RValid(oG_RValid),
        .oTile(oTile), .oCoord_X_d(oCoord_X_d), .oCoord_Y_d(oCoord_Y_d),
        .oPix_Valid_d(oPix_Valid_d), .oFrame_Tick(oFrame_Tick)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // External single-port synchronous-read tile memory
    logic [TW-1:0] mem     [2048];
    logic [TW-1:0] ref_mem [2048];
    always @(posedge iCLK) begin
        iMem_RData <= mem[oMem_Addr];
        if (oMem_WE) mem[oMem_Addr] <= oMem_WData;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Expectations indexed by cycle modulo 4: c_* one cycle after a decision, d_* three cycles after
    logic        c_we [4], c_ack [4], c_chk_addr [4], c_tick [4];
    int          c_addr [4], c_wdata [4];
    int          d_x [4], d_y [4], d_rdata [4], d_tile [4];
    logic        d_pv [4], d_rv [4], d_load [4];

    int   tile_model;
    logic vs_prev, pv_prev, vb, granted_last, wr_ok;
    logic rq, rq_we;
    int   rq_addr, rq_wdata;
    int   rst_hold;
    logic rst_done;

    task automatic clear_slot(input int s);
        c_we[s] = 0; c_ack[s] = 0; c_chk_addr[s] = 0; c_tick[s] = 0;
        c_addr[s] = 0; c_wdata[s] = 0;
        d_x[s] = 0; d_y[s] = 0; d_pv[s] = 0; d_rv[s] = 0;
        d_rdata[s] = 0; d_load[s] = 0; d_tile[s] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) clear_slot(i);
        tile_model   = 0;
        vs_prev      = 1;
        pv_prev      = 0;
        vb           = 1;
        granted_last = 0;
    endtask

    task automatic check_all_zero();
        check_eq("rst_addr",   32'(oMem_Addr), 0);
        check_eq("rst_we",     32'(oMem_WE), 0);
        check_eq("rst_wdata",  32'(oMem_WData), 0);
        check_eq("rst_ack",    32'(oG_Ack), 0);
        check_eq("rst_rdata",  32'(oG_RData), 0);
        check_eq("rst_rvalid", 32'(oG_RValid), 0);
        check_eq("rst_tile",   32'(oTile), 0);
        check_eq("rst_xd",     32'(oCoord_X_d), 0);
        check_eq("rst_yd",     32'(oCoord_Y_d), 0);
        check_eq("rst_pvd",    32'(oPix_Valid_d), 0);
        check_eq("rst_tick",   32'(oFrame_Tick), 0);
    endtask

    initial begin
        int s, n1, n3, h, ln, fr, px;
        iRST_N = 1; iCoord_X = 0; iCoord_Y = 0; iPix_Valid = 0; iVGA_V_SYNC = 1;
        iG_Req = 0; iG_We = 0; iG_Addr = 0; iG_WData = 0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = TW'($urandom);
            ref_mem[i] = mem[i];
        end
        rq = 0; rq_we = 0; rq_addr = 0; rq_wdata = 0;
        rst_hold = 0; rst_done = 0;
        model_reset();
        #1 iRST_N = 0;
        #2 check_all_zero();
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRST_N = 1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge iCLK); #1;
            s = cyc % 4;
            check_eq("mem_we",  32'(oMem_WE), 32'(c_we[s]));
            check_eq("g_ack",   32'(oG_Ack), 32'(c_ack[s]));
            check_eq("f_tick",  32'(oFrame_Tick), 32'(c_tick[s]));
            if (c_chk_addr[s]) check_eq("mem_addr", 32'(oMem_Addr), c_addr[s]);
            if (c_we[s]) check_eq("mem_wdata", 32'(oMem_WData), c_wdata[s]);
            check_eq("coord_x_d", 32'(oCoord_X_d), d_x[s]);
            check_eq("coord_y_d", 32'(oCoord_Y_d), d_y[s]);
            check_eq("pix_v_d",   32'(oPix_Valid_d), 32'(d_pv[s]));
            check_eq("g_rvalid",  32'(oG_RValid), 32'(d_rv[s]));
            if (d_rv[s]) check_eq("g_rdata", 32'(oG_RData), d_rdata[s]);
            if (d_load[s]) tile_model = d_tile[s];
            check_eq("tile", 32'(oTile), tile_model);
            clear_slot(s);

            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold != 0) continue;
                iRST_N = 1;
            end else if (!rst_done && cyc >= 1500 && rq && !granted_last && iVGA_V_SYNC && iPix_Valid) begin
                iRST_N = 0;
                #1 check_all_zero();
                model_reset();
                rst_done = 1;
                rst_hold = 3;
                continue;
            end

            h  = cyc % 80;
            ln = (cyc / 80) % 8;
            fr = cyc / 640;
            iPix_Valid  = (ln < 6) && (h < 64);
            iCoord_X    = 10'(h + 16 * (fr % 3));
            iCoord_Y    = 10'(ln * 16 + 5 * (fr % 4));
            iVGA_V_SYNC = (ln != 6);

            if (granted_last) rq = 0;
            if (!rq && $urandom_range(0, 2) == 0) begin
                rq       = 1;
                rq_we    = 1'($urandom);
                rq_addr  = ($urandom_range(0, 7) == 0) ? 1200 + $urandom_range(0, 847) : $urandom_range(0, 1199);
                rq_wdata = $urandom_range(0, (1 << TW) - 1);
            end
            iG_Req   = rq;
            iG_We    = rq_we;
            iG_Addr  = 11'(rq_addr);
            iG_WData = TW'(rq_wdata);

`ifdef VGA_TILE_FRAME_LOCK_EN
            wr_ok = vb;
`else
            wr_ok = 1;
`endif
            n1 = (cyc + 1) % 4;
            n3 = (cyc + 3) % 4;
            granted_last = 0;
            px = (int'(iCoord_Y) / 16) * 40 + int'(iCoord_X) / 16;
            if (iPix_Valid && (iCoord_X % 16) == 0) begin
                c_chk_addr[n1] = 1;
                c_addr[n1]     = px;
                d_load[n3]     = 1;
                d_tile[n3]     = int'(ref_mem[px]);
            end else if (rq && (!rq_we || wr_ok)) begin
                granted_last   = 1;
                c_ack[n1]      = 1;
                c_chk_addr[n1] = (rq_addr < 1200);
                c_addr[n1]     = rq_addr;
                if (rq_we) begin
                    if (rq_addr < 1200) begin
                        c_we[n1]         = 1;
                        c_wdata[n1]      = rq_wdata;
                        ref_mem[rq_addr] = TW'(rq_wdata);
                    end
                end else begin
                    d_rv[n3]    = 1;
                    d_rdata[n3] = (rq_addr < 1200) ? int'(ref_mem[rq_addr]) : 0;
                end
            end
            c_tick[n1] = vs_prev && !iVGA_V_SYNC;
            d_x[n3]  = int'(iCoord_X);
            d_y[n3]  = int'(iCoord_Y);
            d_pv[n3] = iPix_Valid;

            if (vs_prev && !iVGA_V_SYNC) vb = 1;
            else if (iPix_Valid && !pv_prev) vb = 0;
            vs_prev = iVGA_V_SYNC;
            pv_prev = iPix_Valid;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
